// File: rtl/rf_write_arbiter_if.sv
// Writeback-to-register-file write-port bundle: two requester handshakes plus the
// registered write port and the clear-sweep busy flag.
interface rf_write_arbiter_if #(
    parameter int AD_bit   = 3,
    parameter int Data_bit = 8
);
    logic                a_valid;
    logic [AD_bit-1:0]   a_AD;
    logic [Data_bit-1:0] a_D;
    logic                a_ready;

    logic                b_valid;
    logic [AD_bit-1:0]   b_AD;
    logic [Data_bit-1:0] b_D;
    logic                b_ready;

    logic                WE;
    logic [AD_bit-1:0]   w_AD;
    logic [Data_bit-1:0] w_D;
    logic                busy;

    // master: the writeback stage (and register file) side
    modport master (
        output a_valid, a_AD, a_D, b_valid, b_AD, b_D,
        input  a_ready, b_ready, WE, w_AD, w_D, busy
    );

    // slave: the arbiter
    modport slave (
        input  a_valid, a_AD, a_D, b_valid, b_AD, b_D,
        output a_ready, b_ready, WE, w_AD, w_D, busy
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, with $zero write drop.
// Optional post-reset zero sweep of every location is compiled in by defining RF_CLEAR_EN.
module rf_write_arbiter #(
    parameter int AD_bit   = 3,
    parameter int Data_bit = 8
) (
    input  logic             CLK,
    input  logic             RST_n,
    rf_write_arbiter_if.slave wb
);

    localparam int NREQ = 2;

`ifdef RF_CLEAR_EN
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;
    localparam logic [AD_bit:0] CNT_ONE = {{AD_bit{1'b0}}, 1'b1};
    logic [AD_bit:0]     clr_cnt_reg;
    logic                busy_reg;
`else
    typedef enum logic {ST_RUN} state_t;
`endif

    state_t              state_reg;
    logic                last_b_reg;
    logic                we_reg;
    logic [AD_bit-1:0]   w_ad_reg;
    logic [Data_bit-1:0] w_d_reg;

    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_grant;
    logic [AD_bit-1:0]   req_ad [NREQ];
    logic [Data_bit-1:0] req_d  [NREQ];
    logic                run_ok;
    logic                grant_any;
    logic [AD_bit-1:0]   grant_ad;
    logic [Data_bit-1:0] grant_d;

    // Index 0 is requester A (ALU), index 1 is requester B (load).
    assign req_valid = {wb.b_valid, wb.a_valid};
    assign req_ad[0] = wb.a_AD;
    assign req_ad[1] = wb.b_AD;
    assign req_d[0]  = wb.a_D;
    assign req_d[1]  = wb.b_D;

    // Ready is forced low during reset so nothing can be accepted on a reset edge.
    assign run_ok = RST_n && (state_reg == ST_RUN);

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            // A wins a tie when B went last, B wins when A went last.
            assign req_grant[gi] = run_ok && req_valid[gi] &&
                                   (!req_valid[NREQ-1-gi] || (last_b_reg == (gi == 0)));
        end
    endgenerate

    assign grant_any = |req_grant;
    assign grant_ad  = req_grant[1] ? req_ad[1] : req_ad[0];
    assign grant_d   = req_grant[1] ? req_d[1]  : req_d[0];

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            we_reg     <= 1'b0;
            w_ad_reg   <= '0;
            w_d_reg    <= '0;
            last_b_reg <= 1'b1;
`ifdef RF_CLEAR_EN
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= '0;
            busy_reg    <= 1'b1;
`else
            state_reg   <= ST_RUN;
`endif
        end else begin
`ifdef RF_CLEAR_EN
            if (state_reg == ST_CLEAR) begin
                // Counter MSB set means the last address has been issued; drop WE and hand over.
                if (clr_cnt_reg[AD_bit]) begin
                    we_reg    <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_RUN;
                end else begin
                    we_reg      <= 1'b1;
                    w_ad_reg    <= clr_cnt_reg[AD_bit-1:0];
                    w_d_reg     <= '0;
                    clr_cnt_reg <= clr_cnt_reg + CNT_ONE;
                end
            end else
`endif
            begin
                if (grant_any) begin
                    // Writes to $zero complete the handshake but never reach the file.
                    we_reg     <= (grant_ad != '0);
                    w_ad_reg   <= grant_ad;
                    w_d_reg    <= grant_d;
                    last_b_reg <= req_grant[1];
                end else begin
                    we_reg <= 1'b0;
                end
            end
        end
    end

    assign wb.a_ready = req_grant[0];
    assign wb.b_ready = req_grant[1];
    assign wb.WE      = we_reg;
    assign wb.w_AD    = w_ad_reg;
    assign wb.w_D     = w_d_reg;
`ifdef RF_CLEAR_EN
    assign wb.busy    = busy_reg;
`else
    assign wb.busy    = 1'b0;
`endif

endmodule
